// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-to-ALU pipeline register with EX/WB forwarding,
// immediate select, load-use stall, WB refresh of a held entry and flush.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int OPW  = 6,
    parameter int REGW = 5
) (
    input  logic            clk_i,
    input  logic            issue_rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [OPW-1:0]  in_aluop_i,
    input  logic [REGW-1:0] in_rs1_i,
    input  logic [REGW-1:0] in_rs2_i,
    input  logic [REGW-1:0] in_rd_i,
    input  logic            in_use_imm_i,
    input  logic [XLEN-1:0] in_imm_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            ex_we_i,
    input  logic            ex_is_load_i,
    input  logic [REGW-1:0] ex_rd_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic            wb_we_i,
    input  logic [REGW-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_result_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [OPW-1:0]  ALUop_o,
    output logic [XLEN-1:0] operand_A_o,
    output logic [XLEN-1:0] operand_B_o,
    output logic [REGW-1:0] rd_o
);
    logic            valid_q, valid_d;
    logic [OPW-1:0]  aluop_q, aluop_d;
    logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [REGW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic            use_imm_q, use_imm_d;
    logic            hazard, accept, held;
    logic [XLEN-1:0] rs1_res, rs2_res;

    always_comb begin
        hazard = ex_is_load_i & ex_we_i & (ex_rd_i != '0) & in_valid_i &
                 ((ex_rd_i == in_rs1_i) | (!in_use_imm_i & (ex_rd_i == in_rs2_i)));
        in_ready_o = !flush_i & !hazard & (!valid_q | out_ready_i);
        accept = in_valid_i & in_ready_o;
        held = valid_q & !out_ready_i;
        // Register 0 is hardwired to zero and never forwarded
        rs1_res = (in_rs1_i == '0) ? '0 :
                  (ex_we_i & !ex_is_load_i & (ex_rd_i == in_rs1_i)) ? ex_result_i :
                  (wb_we_i & (wb_rd_i == in_rs1_i)) ? wb_result_i : rs1_data_i;
        rs2_res = (in_rs2_i == '0) ? '0 :
                  (ex_we_i & !ex_is_load_i & (ex_rd_i == in_rs2_i)) ? ex_result_i :
                  (wb_we_i & (wb_rd_i == in_rs2_i)) ? wb_result_i : rs2_data_i;
        valid_d = flush_i ? 1'b0 : accept ? 1'b1 : (valid_q & out_ready_i) ? 1'b0 : valid_q;
        aluop_d = accept ? in_aluop_i : aluop_q;
        rd_d = accept ? in_rd_i : rd_q;
        rs1_d = accept ? in_rs1_i : rs1_q;
        rs2_d = accept ? in_rs2_i : rs2_q;
        use_imm_d = accept ? in_use_imm_i : use_imm_q;
        // A stalled entry picks up WB writes so it never goes stale
        opa_d = accept ? rs1_res :
                (held & wb_we_i & (rs1_q != '0) & (wb_rd_i == rs1_q)) ? wb_result_i : opa_q;
        opb_d = accept ? (in_use_imm_i ? in_imm_i : rs2_res) :
                (held & wb_we_i & !use_imm_q & (rs2_q != '0) & (wb_rd_i == rs2_q)) ? wb_result_i : opb_q;
    end

    always_ff @(posedge clk_i) begin
        if (!issue_rst_i) begin
            valid_q   <= 1'b0;
            aluop_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            aluop_q   <= aluop_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
        end
    end

    assign out_valid_o = valid_q;
    assign ALUop_o     = aluop_q;
    assign operand_A_o = opa_q;
    assign operand_B_o = opb_q;
    assign rd_o        = rd_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;
    logic        clk_i = 0, issue_rst_i, flush_i, in_valid_i, in_ready_o;
    logic [5:0]  in_aluop_i, ALUop_o;
    logic [4:0]  in_rs1_i, in_rs2_i, in_rd_i, ex_rd_i, wb_rd_i, rd_o;
    logic        in_use_imm_i, ex_we_i, ex_is_load_i, wb_we_i, out_valid_o, out_ready_i;
    logic [31:0] in_imm_i, rs1_data_i, rs2_data_i, ex_result_i, wb_result_i;
    logic [31:0] operand_A_o, operand_B_o;
    int n_cmp = 0, n_bad = 0;

    always #5 clk_i = ~clk_i;

    alu_issue_stage dut (
        .clk_i(clk_i), .issue_rst_i(issue_rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_aluop_i(in_aluop_i),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i),
        .in_use_imm_i(in_use_imm_i), .in_imm_i(in_imm_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .ex_we_i(ex_we_i), .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i), .ex_result_i(ex_result_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_result_i(wb_result_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .ALUop_o(ALUop_o),
        .operand_A_o(operand_A_o), .operand_B_o(operand_B_o), .rd_o(rd_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        issue_rst_i = 0; flush_i = 0; in_valid_i = 1; in_aluop_i = 6'd5;
        in_rs1_i = 5'd1; in_rs2_i = 5'd2; in_rd_i = 5'd3; in_use_imm_i = 0; in_imm_i = 32'h0;
        rs1_data_i = 32'h1234; rs2_data_i = 32'h5678;
        ex_we_i = 0; ex_is_load_i = 0; ex_rd_i = 0; ex_result_i = 0;
        wb_we_i = 0; wb_rd_i = 0; wb_result_i = 0; out_ready_i = 1;
        step(); step();
        chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
        chk("rst_aluop", {26'b0, ALUop_o}, 32'd0);
        chk("rst_opa", operand_A_o, 32'd0);
        chk("rst_opb", operand_B_o, 32'd0);
        chk("rst_rd", {27'b0, rd_o}, 32'd0);

        // Forwarding priority EX > WB > regfile, rs0 forced to zero
        issue_rst_i = 1; in_aluop_i = 6'd1; in_rs1_i = 5'd5; rs1_data_i = 32'h1;
        in_use_imm_i = 1; in_imm_i = 32'h77; in_rd_i = 5'd9;
        ex_we_i = 1; ex_rd_i = 5'd5; ex_result_i = 32'hAA;
        wb_we_i = 1; wb_rd_i = 5'd5; wb_result_i = 32'hBB;
        #1 chk("fwd_ready", {31'b0, in_ready_o}, 32'd1);
        step();
        chk("fwd_valid", {31'b0, out_valid_o}, 32'd1);
        chk("fwd_ex", operand_A_o, 32'hAA);
        chk("fwd_imm", operand_B_o, 32'h77);
        chk("fwd_rd", {27'b0, rd_o}, 32'd9);
        chk("fwd_aluop", {26'b0, ALUop_o}, 32'd1);
        ex_we_i = 0;
        step();
        chk("fwd_wb", operand_A_o, 32'hBB);
        in_rs1_i = 5'd0; ex_we_i = 1; ex_rd_i = 5'd0; wb_rd_i = 5'd0;
        step();
        chk("fwd_x0", operand_A_o, 32'h0);

        // Load-use hazard on rs2, then the same op using an immediate
        ex_we_i = 1; ex_is_load_i = 1; ex_rd_i = 5'd7; wb_we_i = 0;
        in_rs1_i = 5'd2; rs1_data_i = 32'h22; in_rs2_i = 5'd7; in_use_imm_i = 0; in_aluop_i = 6'd3;
        #1 chk("lu_stall", {31'b0, in_ready_o}, 32'd0);
        step();
        chk("lu_bubble", {31'b0, out_valid_o}, 32'd0);
        in_use_imm_i = 1; in_imm_i = 32'h1234;
        #1 chk("lu_imm_ready", {31'b0, in_ready_o}, 32'd1);
        step();
        chk("lu_imm_valid", {31'b0, out_valid_o}, 32'd1);
        chk("lu_imm_opb", operand_B_o, 32'h1234);
        chk("lu_imm_opa", operand_A_o, 32'h22);
        ex_we_i = 0; ex_is_load_i = 0; in_valid_i = 0;
        step();
        chk("lu_drain", {31'b0, out_valid_o}, 32'd0);

        // Backpressure with WB refresh of the held rs1 operand
        in_valid_i = 1; in_rs1_i = 5'd3; rs1_data_i = 32'h10; in_imm_i = 32'h0; in_aluop_i = 6'd4;
        out_ready_i = 0;
        step();
        chk("bp_valid", {31'b0, out_valid_o}, 32'd1);
        chk("bp_opa", operand_A_o, 32'h10);
        in_aluop_i = 6'd6; rs1_data_i = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", {31'b0, in_ready_o}, 32'd0);
            step();
            chk("bp_hold_opa", operand_A_o, 32'h10);
            chk("bp_hold_op", {26'b0, ALUop_o}, 32'd4);
        end
        wb_we_i = 1; wb_rd_i = 5'd3; wb_result_i = 32'h55;
        step();
        chk("bp_refresh", operand_A_o, 32'h55);
        chk("bp_ready2", {31'b0, in_ready_o}, 32'd0);
        wb_we_i = 0; in_valid_i = 0; out_ready_i = 1;
        step();
        chk("bp_consumed", {31'b0, out_valid_o}, 32'd0);
        chk("bp_keep_op", {26'b0, ALUop_o}, 32'd4);

        // Back-to-back with an rs2 WB forward on the second op
        in_valid_i = 1; in_aluop_i = 6'd0;
        step();
        chk("b2b_v0", {31'b0, out_valid_o}, 32'd1);
        chk("b2b_op0", {26'b0, ALUop_o}, 32'd0);
        in_aluop_i = 6'd1; in_use_imm_i = 0; in_rs2_i = 5'd4; rs2_data_i = 32'h44;
        wb_we_i = 1; wb_rd_i = 5'd4; wb_result_i = 32'hCC;
        step();
        chk("b2b_v1", {31'b0, out_valid_o}, 32'd1);
        chk("b2b_op1", {26'b0, ALUop_o}, 32'd1);
        chk("b2b_rs2_wb", operand_B_o, 32'hCC);
        wb_we_i = 0; in_aluop_i = 6'd2;
        step();
        chk("b2b_v2", {31'b0, out_valid_o}, 32'd1);
        chk("b2b_op2", {26'b0, ALUop_o}, 32'd2);
        chk("b2b_rs2_rf", operand_B_o, 32'h44);

        // Flush drops the held entry and refuses the incoming op
        in_valid_i = 0; out_ready_i = 0;
        step();
        chk("fl_held", {31'b0, out_valid_o}, 32'd1);
        in_valid_i = 1; in_aluop_i = 6'd9; flush_i = 1;
        #1 chk("fl_ready", {31'b0, in_ready_o}, 32'd0);
        step();
        chk("fl_valid", {31'b0, out_valid_o}, 32'd0);
        chk("fl_nocap", {26'b0, ALUop_o}, 32'd2);
        flush_i = 0; in_valid_i = 0;
        step();
        chk("fl_idle", {31'b0, out_valid_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
